// File: rtl/iir_biquad_cascade_pkg.sv
// Shared types and helpers for the biquad cascade: FSM states, tap indices,
// and the round-then-saturate step applied to each section's accumulator.
package iir_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MAC    = 2'd1,
        S_COMMIT = 2'd2,
        S_OUT    = 2'd3
    } iir_state_t;

    localparam int TAPS = 5;

    localparam logic [2:0] B0 = 3'd0;
    localparam logic [2:0] B1 = 3'd1;
    localparam logic [2:0] B2 = 3'd2;
    localparam logic [2:0] A1 = 3'd3;
    localparam logic [2:0] A2 = 3'd4;

    // Round half-up at bit FRAC, arithmetic shift, then clamp to data_w signed.
    function automatic logic signed [63:0] round_sat(
        input  logic signed [63:0] acc,
        input  int                 frac,
        input  int                 data_w,
        output logic               sat
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (frac > 0) begin
            r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        end
        hi  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (data_w - 1));
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Sample, coefficient and status signals of the biquad cascade core.
interface iir_biquad_cascade_if #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int SECTIONS = 4
);
    localparam int ADDR_W = $clog2(5 * SECTIONS);

    // Input handshake: a sample transfers on a rising clk edge where in_valid
    // and in_ready are both high; in_valid/din must stay stable until then.
    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] din;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] dout;
    logic                     busy;
    logic                     sat_flag;
    iir_pkg::iir_state_t      dbg_state;

    modport master (
        output clear, in_valid, din, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, dout, busy, sat_flag, dbg_state
    );

    modport slave (
        input  clear, in_valid, din, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, dout, busy, sat_flag, dbg_state
    );

endinterface

// File: rtl/iir_biquad_cascade_mac.sv
// Signed multiply-accumulate shared by all taps and sections; i_clr starts a
// new sum with the current product, i_sub subtracts it instead of adding.
module iir_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = DATA_W + COEF_W + 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic                     i_sub,
    input  logic signed [COEF_W-1:0] i_coef,
    input  logic signed [DATA_W-1:0] i_data,
    output logic signed [ACC_W-1:0]  o_acc
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_prod = PROD_W'(i_coef) * PROD_W'(i_data);
    assign w_term = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_base = i_clr ? '0 : r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_sub ? (w_base - w_term) : (w_base + w_term);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of Direct-Form-I biquads time-sharing one MAC: five MAC cycles plus
// one commit cycle per section, then one cycle to present the result.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int FRAC     = 14,
    parameter int SECTIONS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    iir_biquad_cascade_if.slave  bus
);
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int NCOEF  = TAPS * SECTIONS;
    localparam int ADDR_W = $clog2(NCOEF);
    localparam int SEC_W  = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << FRAC);

    iir_state_t r_state;
    iir_state_t w_next;

    logic [SEC_W-1:0]         r_sec;
    logic [2:0]               r_tap;
    logic signed [DATA_W-1:0] r_xin;
    logic signed [DATA_W-1:0] r_x1 [SECTIONS];
    logic signed [DATA_W-1:0] r_x2 [SECTIONS];
    logic signed [DATA_W-1:0] r_y1 [SECTIONS];
    logic signed [DATA_W-1:0] r_y2 [SECTIONS];
    logic signed [COEF_W-1:0] r_coef [NCOEF];
    logic                     r_out_valid;
    logic signed [DATA_W-1:0] r_dout;
    logic                     r_sat;

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_clear;
    logic                     w_coef_wr;
    logic                     w_mac_en;
    logic                     w_last;
    logic [ADDR_W-1:0]        w_cidx;
    logic signed [DATA_W-1:0] w_mac_data;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [63:0]       w_acc64;
    logic signed [63:0]       w_round;
    logic                     w_sat;
    logic signed [DATA_W-1:0] w_y;
    logic                     w_unused_hi;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_accept   = 1'b0;
        w_clear    = 1'b0;
        w_coef_wr  = 1'b0;
        w_mac_en   = 1'b0;
        w_last     = (r_sec == SEC_W'(SECTIONS - 1));
        case (r_state)
            S_IDLE: begin
                // clear wins over a new sample in the same cycle
                w_in_ready = reset && clk_en && !bus.clear;
                w_clear    = clk_en && bus.clear;
                w_coef_wr  = clk_en && bus.coef_we && (int'(bus.coef_addr) < NCOEF);
                w_accept   = w_in_ready && bus.in_valid;
                if (w_accept) begin
                    w_next = S_MAC;
                end
            end
            S_MAC: begin
                w_mac_en = clk_en;
                if (r_tap == A2) begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: w_next = w_last ? S_OUT : S_MAC;
            S_OUT:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_cidx = ADDR_W'(int'(r_sec) * TAPS + int'(r_tap));

    always_comb begin
        w_mac_data = r_xin;
        case (r_tap)
            B1:      w_mac_data = r_x1[r_sec];
            B2:      w_mac_data = r_x2[r_sec];
            A1:      w_mac_data = r_y1[r_sec];
            A2:      w_mac_data = r_y2[r_sec];
            default: w_mac_data = r_xin;
        endcase
    end

    iir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_mac_en),
        .i_clr  (r_tap == B0),
        .i_sub  (r_tap >= A1),
        .i_coef (r_coef[w_cidx]),
        .i_data (w_mac_data),
        .o_acc  (w_acc)
    );

    assign w_acc64 = {{(64 - ACC_W){w_acc[ACC_W-1]}}, w_acc};

    always_comb begin
        w_sat   = 1'b0;
        w_round = round_sat(w_acc64, FRAC, DATA_W, w_sat);
    end

    assign w_y         = w_round[DATA_W-1:0];
    assign w_unused_hi = ^w_round[63:DATA_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sec       <= '0;
            r_tap       <= B0;
            r_xin       <= '0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_sat       <= 1'b0;
            for (int i = 0; i < SECTIONS; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else if (clk_en) begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_clear) begin
                        r_sat <= 1'b0;
                        for (int i = 0; i < SECTIONS; i++) begin
                            r_x1[i] <= '0;
                            r_x2[i] <= '0;
                            r_y1[i] <= '0;
                            r_y2[i] <= '0;
                        end
                    end
                    if (w_accept) begin
                        r_xin <= bus.din;
                        r_sec <= '0;
                        r_tap <= B0;
                    end
                end
                S_MAC: r_tap <= r_tap + 3'd1;
                S_COMMIT: begin
                    // this section's output becomes the next section's input
                    r_x2[r_sec] <= r_x1[r_sec];
                    r_x1[r_sec] <= r_xin;
                    r_y2[r_sec] <= r_y1[r_sec];
                    r_y1[r_sec] <= w_y;
                    r_xin       <= w_y;
                    r_tap       <= B0;
                    if (w_sat) begin
                        r_sat <= 1'b1;
                    end
                    if (!w_last) begin
                        r_sec <= r_sec + 1'b1;
                    end
                end
                S_OUT: begin
                    r_dout      <= r_xin;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCOEF; i++) begin
                r_coef[i] <= (i % TAPS == 0) ? UNITY : '0;
            end
        end else if (w_coef_wr) begin
            r_coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.sat_flag  = r_sat;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Bench for iir_biquad_cascade: directed scenarios plus random samples,
// checked by a scoreboard fed from an arithmetic reference of the cascade.
module tb_iir_biquad_cascade;
    import iir_pkg::*;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int FRAC = 14;
    localparam int S    = 4;
    localparam int NC   = TAPS * S;
    localparam int AW   = $clog2(NC);
    localparam int LAT  = 6 * S + 1;

    logic clk;
    logic reset;
    logic clk_en;

    iir_biquad_cascade_if #(.DATA_W(DW), .COEF_W(CW), .SECTIONS(S)) bus ();

    iir_biquad_cascade #(
        .DATA_W   (DW),
        .COEF_W   (CW),
        .FRAC     (FRAC),
        .SECTIONS (S)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    logic [DW:0] exp_q[$];
    int          lat_q[$];

    int m_coef [NC];
    int m_x1 [S];
    int m_x2 [S];
    int m_y1 [S];
    int m_y2 [S];
    bit m_sat;

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // reference model: y = clamp(floor((sum + 2^(FRAC-1)) / 2^FRAC))
    task automatic model_clear();
        for (int s = 0; s < S; s++) begin
            m_x1[s] = 0;
            m_x2[s] = 0;
            m_y1[s] = 0;
            m_y2[s] = 0;
        end
        m_sat = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) m_coef[i] = (i % TAPS == 0) ? (1 << FRAC) : 0;
        model_clear();
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && (n < 0)) q = q - 1;
        return q;
    endfunction

    task automatic model_step(input int x, output int y);
        longint acc;
        longint q;
        longint hi;
        longint lo;
        int     v;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        v  = x;
        for (int s = 0; s < S; s++) begin
            acc = longint'(m_coef[s*TAPS+0]) * v
                + longint'(m_coef[s*TAPS+1]) * m_x1[s]
                + longint'(m_coef[s*TAPS+2]) * m_x2[s]
                - longint'(m_coef[s*TAPS+3]) * m_y1[s]
                - longint'(m_coef[s*TAPS+4]) * m_y2[s];
            q = floor_div(acc + (longint'(1) << (FRAC - 1)), longint'(1) << FRAC);
            if (q > hi) begin
                q = hi;
                m_sat = 1'b1;
            end else if (q < lo) begin
                q = lo;
                m_sat = 1'b1;
            end
            m_x2[s] = m_x1[s];
            m_x1[s] = v;
            m_y2[s] = m_y1[s];
            m_y1[s] = int'(q);
            v = int'(q);
        end
        y = v;
    endtask

    // driver tasks
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) timeout_fail("wait_idle");
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic signed [CW-1:0] d);
        wait_idle();
        bus.coef_we   = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
        if (int'(a) < NC) m_coef[a] = d;
    endtask

    task automatic do_clear();
        wait_idle();
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.din      = DW'(1234);
        #1;
        check("clear_blocks_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        check("clear_sample_not_taken", bus.busy, 0);
        check("clear_sat_flag", bus.sat_flag, 0);
        model_clear();
    endtask

    // we_mode: 0 none, 1 coefficient write on the accepting edge, 2 write while busy
    task automatic send(input logic signed [DW-1:0] x, input int stall_after, input int stall_len,
                        input int we_mode, input logic [AW-1:0] wa,
                        input logic signed [CW-1:0] wd, input bit expect_out);
        int n;
        int y;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            timeout_fail("in_ready_wait");
            return;
        end
        bus.in_valid = 1'b1;
        bus.din      = x;
        if (we_mode == 1) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = wa;
            bus.coef_data = wd;
            if (int'(wa) < NC) m_coef[wa] = wd;
        end
        if (expect_out) begin
            model_step(int'(x), y);
            exp_q.push_back({m_sat, DW'(y)});
            lat_q.push_back(LAT + stall_len);
        end
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        if (we_mode == 2) begin
            @(negedge clk);
            bus.coef_we   = 1'b1;
            bus.coef_addr = wa;
            bus.coef_data = wd;
            @(negedge clk);
            bus.coef_we = 1'b0;
        end
        if (stall_len > 0) begin
            repeat (stall_after) @(negedge clk);
            clk_en = 1'b0;
            repeat (stall_len) @(negedge clk);
            clk_en = 1'b1;
        end
    endtask

    task automatic send_plain(input logic signed [DW-1:0] x);
        send(x, 0, 0, 0, '0, '0, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) timeout_fail("drain");
    endtask

    // scoreboard monitor
    logic [DW:0] mon_e;
    int          mon_l;

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=%0d required=none", bus.dout);
            end else begin
                mon_e = exp_q.pop_front();
                mon_l = lat_q.pop_front();
                check("dout", bus.dout, $signed(mon_e[DW-1:0]));
                check("sat_flag", bus.sat_flag, mon_e[DW]);
                check("latency", cyc - acc_cyc, mon_l);
            end
        end
    end

    int r;
    int st_len;
    int wm;

    initial begin
        reset         = 1'b0;
        clk_en        = 1'b1;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sat_flag", bus.sat_flag, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_state", int'(bus.dbg_state), int'(S_IDLE));
        check("idle_in_ready", bus.in_ready, 1);

        // passthrough defaults
        send_plain(DW'(1000));
        drain();

        // FIR section: b0=b1=b2=0.5, impulse response
        write_coef(AW'(0), CW'(8192));
        write_coef(AW'(1), CW'(8192));
        write_coef(AW'(2), CW'(8192));
        do_clear();
        send_plain(DW'(16384));
        send_plain(DW'(0));
        send_plain(DW'(0));
        send_plain(DW'(0));
        drain();

        // feedback +0.5*y1, step input
        write_coef(AW'(0), CW'(16384));
        write_coef(AW'(1), CW'(0));
        write_coef(AW'(2), CW'(0));
        write_coef(AW'(3), -CW'(8192));
        do_clear();
        repeat (4) send_plain(DW'(1000));
        drain();

        // saturation, then clear wipes sat_flag and the delay lines
        write_coef(AW'(3), CW'(0));
        write_coef(AW'(0), CW'(32767));
        write_coef(AW'(1), CW'(16384));
        do_clear();
        send_plain(DW'(30000));
        drain();
        do_clear();
        write_coef(AW'(0), CW'(16384));
        send_plain(DW'(100));
        drain();
        write_coef(AW'(1), CW'(0));

        // 7-cycle stall mid-MAC plus a write attempted while busy
        send(DW'(1234), 2, 7, 2, AW'(0), CW'(0), 1'b1);
        drain();
        send_plain(-DW'(2222));
        drain();

        // write landing on the accepting edge is used by that sample
        send(DW'(500), 0, 0, 1, AW'(0), CW'(8192), 1'b1);
        drain();
        write_coef(AW'(0), CW'(16384));

        // reset in the middle of a computation
        write_coef(AW'(0), CW'(32767));
        send_plain(DW'(30000));
        drain();
        send(DW'(20000), 0, 0, 0, '0, '0, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_dout", bus.dout, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_sat_flag", bus.sat_flag, 0);
        check("abort_in_ready", bus.in_ready, 0);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        send_plain(DW'(30000));
        drain();

        // random coefficients, samples, stalls and clears
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                write_coef(AW'($urandom_range(0, (1 << AW) - 1)), CW'($urandom_range(0, 65535)));
            end else if (r == 2) begin
                do_clear();
            end
            st_len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            wm = $urandom_range(0, 5);
            if (wm > 2) wm = 0;
            send(DW'($urandom_range(0, 65535)), $urandom_range(1, 8), st_len, wm,
                 AW'($urandom_range(0, (1 << AW) - 1)), CW'($urandom_range(0, 65535)), 1'b1);
        end
        drain();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_biquad_cascade.md
# iir_biquad_cascade

Parametrised cascade of Direct-Form-I biquad IIR sections sharing one time-multiplexed multiply-accumulate unit, with run-time loadable coefficients. It is the next-generation filter core behind the sine/noise mixing datapath: it consumes the `mixed` sample stream and produces the filtered output. It generalises the fixed single-filter design in section count, data and coefficient width, and fractional format. It adds an input handshake, a coefficient write port, saturation with a sticky flag, and delay-line clear.

## Interface
- `DATA_W`, 16: signed sample width, in and out.
- `COEF_W`, 16: signed coefficient width.
- `FRAC`, 14: coefficient fractional bits; 1.0 = 2^FRAC.
- `SECTIONS`, 4: number of cascaded biquads, 1..8.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `clk_en`  in  1: global enable; when low, all state freezes.
- `clear`  in  1: synchronous clear of all delay lines; accepted only in IDLE.
- `in_valid`  in  1: `din` valid.
- `in_ready`  out  1: core can accept a sample.
- `din`  in  DATA_W: signed input sample.
- `coef_we`  in  1: coefficient write strobe.
- `coef_addr`  in  clog2(5*SECTIONS): address, section*5+tap; tap order is b0, b1, b2, a1, a2.
- `coef_data`  in  COEF_W: signed coefficient.
- `out_valid`  out  1: one-cycle pulse; `dout` is new.
- `dout`  out  DATA_W: filtered sample; holds until the next result.
- `busy`  out  1: FSM not in IDLE.
- `sat_flag`  out  1: sticky; set on any saturation; cleared by reset or `clear`.

## Operation
- Per section: y = sat(round((b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2) >>> FRAC)).
- Rounding adds 2^(FRAC−1) before the arithmetic shift.
- Saturation clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and sets `sat_flag`.
- The output of section s is the input of section s+1. `dout` is the output of the last section.
- Accumulator width is ACC_W = DATA_W+COEF_W+3 (localparam). The accumulator never wraps.
- FSM states:
  - IDLE: `in_ready`=1 when `clk_en`=1. On `in_valid`&&`in_ready`, latch `din`, set s=0, go to MAC.
  - MAC: one product per cycle, tap 0..4. After tap 4, go to COMMIT.
  - COMMIT: round and saturate. Update the section delays (x2←x1, x1←x, y2←y1, y1←y). Pass y on as the next section input. If s<SECTIONS−1, increment s and go to MAC; otherwise go to OUT.
  - OUT: load `dout`, pulse `out_valid`, go to IDLE.
- Coefficient writes are accepted only in IDLE. A write attempted while busy is dropped, and the coefficients stay unchanged.
- `clear` in IDLE zeroes every x1, x2, y1, y2 and `sat_flag`. `clear` has priority over a simultaneous `in_valid`, which is not accepted that cycle. `clear` while busy is ignored.
- Simultaneous `coef_we` and input acceptance in IDLE: the write lands, and the new sample uses the new value.
- Reset values:
  - FSM = IDLE.
  - `in_ready`=0 while `reset` is low.
  - `out_valid`=0, `dout`=0, `busy`=0, `sat_flag`=0.
  - Delay lines = 0.
  - Coefficients = passthrough: b0 = 2^FRAC, others 0.
- Reset mid-computation aborts the sample. No `out_valid` is issued for it.

## Timing
- Latency from the accepting edge to the `out_valid` edge is 6·SECTIONS+1 enabled cycles (25 at default).
- Throughput is one sample per 6·SECTIONS+2 enabled cycles. `in_ready` is low from acceptance through OUT.
- `clk_en`=0 stalls the FSM, the MAC and all registers. Latency stretches by exactly the number of stalled cycles. `out_valid` is never dropped or duplicated.
- `out_valid` is high for exactly one enabled cycle.

## Structure
- Package `iir_pkg` holds:
  - the FSM state enum;
  - the tap-index constants B0, B1, B2, A1, A2;
  - the TAPS=5 constant;
  - the rounding/saturation helper function.
- Sub-module `iir_mac`: signed COEF_W×DATA_W multiplier plus ACC_W accumulator, with `clr`/`en` controls. It is instantiated once.
- Coefficient storage is a register array of 5·SECTIONS entries. Delay lines are per-section register arrays.

## Test plan
- Reset defaults, SECTIONS=4: `din`=1000 → `dout`=1000, with `out_valid` exactly 25 cycles after acceptance.
- Section 0 set to b0=b1=b2=8192: impulse 16384, then zeros → `dout` sequence 8192, 8192, 8192, 0.
- Section 0 set to a1=−8192 (feedback +0.5·y1): step 1000 → `dout` 1000, 1500, 1750, 1875.
- Section 0 set to b0=32767: `din`=30000 → `dout`=32767 and `sat_flag`=1. Then `clear` → `sat_flag`=0 and delays zeroed.
- `clk_en` held low for 7 cycles mid-MAC → `out_valid` at cycle 32, with a value identical to the unstalled run. A `coef_we` issued while busy has no effect.
- `reset` asserted at cycle 10 of a computation → all outputs at reset values, no `out_valid`. The next sample is filtered with passthrough coefficients.
